// File: rtl/cell_comm_rx_decoder.sv
// cell_comm_rx_decoder
//   Receive-side decoder for cell-controller BPM packets on one Aurora link.
//   It parses 4-beat frames (header, X, Y, S) from the RX AXI-stream and emits one
//   registered position record per clean frame. It also counts good frames, CRC
//   faults and framing errors.
//   Optional feature macro: CELL_RX_DUP_DETECT_EN (seen-index bitmap + dupCount).
module cell_comm_rx_decoder #(
    parameter int         FOFB_IDX_WIDTH = 9,
    parameter int         ADC_COUNT      = 4,
    parameter int         DATA_WIDTH     = 32,
    parameter logic [7:0] MAGIC          = 8'hA5
) (
    input  logic                      auroraUserClk,
    input  logic                      auroraUserReset,
    input  logic                      channelUp,
    input  logic                      axisRxTvalid,
    input  logic                      axisRxTlast,
    input  logic [31:0]               axisRxTdata,
    input  logic                      axisRxCRCvalid,
    input  logic                      axisRxCRCpass,
    input  logic                      clearSeen,
    output logic                      posValid,
    output logic [FOFB_IDX_WIDTH-1:0] posIdx,
    output logic [DATA_WIDTH-1:0]     posX,
    output logic [DATA_WIDTH-1:0]     posY,
    output logic [DATA_WIDTH-1:0]     posS,
    output logic [ADC_COUNT-1:0]      posClip,
    output logic [31:0]               goodCount,
    output logic [31:0]               crcFaultCount,
    output logic [31:0]               framingErrCount,
    output logic [31:0]               dupCount
);
    localparam logic [2:0] ST_HDR   = 3'd0;
    localparam logic [2:0] ST_X     = 3'd1;
    localparam logic [2:0] ST_Y     = 3'd2;
    localparam logic [2:0] ST_S     = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [FOFB_IDX_WIDTH-1:0] idx_q;
    logic [ADC_COUNT-1:0]      clip_q;
    logic [DATA_WIDTH-1:0]     x_q, y_q;
    logic                      ld_hdr, ld_x, ld_y;
    logic                      ev_good, ev_crc, ev_fr;
    logic                      pos_valid_q;
    logic [FOFB_IDX_WIDTH-1:0] pos_idx_q;
    logic [ADC_COUNT-1:0]      pos_clip_q;
    logic [DATA_WIDTH-1:0]     pos_x_q, pos_y_q, pos_s_q;
    logic [31:0]               good_q, crc_q, fr_q;

    // Frame parser: at most one count event per frame, and framing errors win over CRC.
    always_comb begin
        state_d = state_q;
        ld_hdr  = 1'b0;
        ld_x    = 1'b0;
        ld_y    = 1'b0;
        ev_good = 1'b0;
        ev_crc  = 1'b0;
        ev_fr   = 1'b0;
        if (!channelUp) begin
            state_d = ST_HDR;
        end else if (axisRxTvalid) begin
            case (state_q)
                ST_HDR: begin
                    if (axisRxTdata[31:24] != MAGIC) begin
                        ev_fr   = 1'b1;
                        state_d = axisRxTlast ? ST_HDR : ST_DRAIN;
                    end else if (axisRxTlast) begin
                        ev_fr   = 1'b1;
                    end else begin
                        ld_hdr  = 1'b1;
                        state_d = ST_X;
                    end
                end
                ST_X: begin
                    if (axisRxTlast) begin
                        ev_fr   = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        ld_x    = 1'b1;
                        state_d = ST_Y;
                    end
                end
                ST_Y: begin
                    if (axisRxTlast) begin
                        ev_fr   = 1'b1;
                        state_d = ST_HDR;
                    end else begin
                        ld_y    = 1'b1;
                        state_d = ST_S;
                    end
                end
                ST_S: begin
                    if (!axisRxTlast) begin
                        ev_fr   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        // A missing CRC result is treated the same as a failed one.
                        ev_good = axisRxCRCvalid && axisRxCRCpass;
                        ev_crc  = !(axisRxCRCvalid && axisRxCRCpass);
                        state_d = ST_HDR;
                    end
                end
                ST_DRAIN: begin
                    if (axisRxTlast) state_d = ST_HDR;
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
        if (auroraUserReset) state_q <= ST_HDR;
        else                 state_q <= state_d;
    end

    // Staging for header fields and X/Y; discarded whenever the link drops
    always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
        if (auroraUserReset) begin
            idx_q  <= '0;
            clip_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (!channelUp) begin
            idx_q  <= '0;
            clip_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
        end else begin
            if (ld_hdr) begin
                idx_q  <= axisRxTdata[FOFB_IDX_WIDTH-1:0];
                clip_q <= axisRxTdata[16 +: ADC_COUNT];
            end
            if (ld_x) x_q <= axisRxTdata[DATA_WIDTH-1:0];
            if (ld_y) y_q <= axisRxTdata[DATA_WIDTH-1:0];
        end
    end

    // Output record: pulse valid for one cycle, hold data until the next record
    always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
        if (auroraUserReset) begin
            pos_valid_q <= 1'b0;
            pos_idx_q   <= '0;
            pos_clip_q  <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            pos_s_q     <= '0;
        end else begin
            pos_valid_q <= ev_good;
            if (ev_good) begin
                pos_idx_q  <= idx_q;
                pos_clip_q <= clip_q;
                pos_x_q    <= x_q;
                pos_y_q    <= y_q;
                pos_s_q    <= axisRxTdata[DATA_WIDTH-1:0];
            end
        end
    end

    // Frame statistics; 32-bit counters wrap naturally
    always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
        if (auroraUserReset) begin
            good_q <= '0;
            crc_q  <= '0;
            fr_q   <= '0;
        end else begin
            if (ev_good) good_q <= good_q + 32'd1;
            if (ev_crc)  crc_q  <= crc_q + 32'd1;
            if (ev_fr)   fr_q   <= fr_q + 32'd1;
        end
    end

`ifdef CELL_RX_DUP_DETECT_EN
    logic [(2**FOFB_IDX_WIDTH)-1:0] seen_q, seen_d;
    logic [31:0]                    dup_q;
    logic                           ev_dup;

    // A clear coinciding with a record is applied first, so the record only sets its bit
    always_comb begin
        seen_d = clearSeen ? '0 : seen_q;
        if (ev_good) seen_d[idx_q] = 1'b1;
        ev_dup = ev_good && !clearSeen && seen_q[idx_q];
    end

    // Seen-index bitmap and duplicate counter
    always_ff @(posedge auroraUserClk or posedge auroraUserReset) begin
        if (auroraUserReset) begin
            seen_q <= '0;
            dup_q  <= '0;
        end else begin
            seen_q <= seen_d;
            if (ev_dup) dup_q <= dup_q + 32'd1;
        end
    end

    assign dupCount = dup_q;
`else
    logic unused_clear_seen;
    assign unused_clear_seen = clearSeen;
    assign dupCount          = '0;
`endif

    assign posValid        = pos_valid_q;
    assign posIdx          = pos_idx_q;
    assign posClip         = pos_clip_q;
    assign posX            = pos_x_q;
    assign posY            = pos_y_q;
    assign posS            = pos_s_q;
    assign goodCount       = good_q;
    assign crcFaultCount   = crc_q;
    assign framingErrCount = fr_q;
endmodule
